// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   // Init sequencer states: INIT walks every entry, READY is normal operation.
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   // Number of entries addressed by an addr_w-bit address.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Value loaded into entry idx by the init sequencer; mode 0 clears, otherwise idx.
   function automatic logic [31:0] init_value(input logic [31:0] idx, input int mode);
      return (mode == 0) ? 32'd0 : idx;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: init blanking, zero register, write bypass, array read.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              busy,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              byp_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] rd_data
);

   // Priority select; byp_en is only high for writes that will really commit.
   always_comb begin
      if (busy) begin
         rd_data = '0;
      end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         rd_data = '0;
      end else if (byp_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end else begin
         rd_data = mem_data;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_RD combinational read ports,
// write-to-read bypass, optional zero register and a reset-driven init sequencer.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   parameter int INIT_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     init_busy
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   logic [ADDR_W-1:0] init_idx;
   logic              zero_drop;
   logic              wr_commit;

   // A write commits only outside reset/init and never into the hardwired zero entry.
   assign zero_drop = (ZERO_REG != 0) && (wr_addr == '0);
   assign wr_commit = wr_en && !init_busy && !rst && !zero_drop;

   // Init sequencer: reset restarts at entry 0, one entry per cycle, then READY.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         init_idx  <= '0;
         init_busy <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               init_idx <= init_idx + 1'b1;
               if (init_idx == ADDR_W'(DEPTH - 1)) begin
                  state     <= READY;
                  init_busy <= 1'b0;
               end
            end
            READY: begin
               state <= READY;
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Array update: init load while sequencing, otherwise committed writes; never reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[init_idx] <= DATA_W'(init_value(32'(init_idx), INIT_MODE));
         end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .busy     (init_busy),
         .rd_addr  (addr),
         .byp_en   (wr_commit),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .mem_data (mem[addr]),
         .rd_data  (rd_data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven side by side and compared
// against an array-based reference model of the register file rules.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        we0, we1, we2;
   logic [4:0]  wa0, wa1;
   logic [2:0]  wa2;
   logic [31:0] wd0, wd1;
   logic [15:0] wd2;
   logic [9:0]  ra0, ra1;
   logic [11:0] ra2;
   logic [63:0] rdd0, rdd1, rdd2;
   logic        busy0, busy1, busy2;

   int checks   = 0;
   int failures = 0;

   // d0: defaults. d1: no zero register, init to zero. d2: 4 ports, 16-bit, 8 entries.
   regfile_mp u_d0 (
      .clk(clk), .rst(rst), .rd_addr(ra0), .rd_data(rdd0),
      .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .init_busy(busy0));

   regfile_mp #(.ZERO_REG(0), .INIT_MODE(0)) u_d1 (
      .clk(clk), .rst(rst), .rd_addr(ra1), .rd_data(rdd1),
      .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .init_busy(busy1));

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_d2 (
      .clk(clk), .rst(rst), .rd_addr(ra2), .rd_data(rdd2),
      .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .init_busy(busy2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   // Reference model: per-configuration contents plus init progress.
   int          dep [3] = '{32, 32, 8};
   bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
   bit          im  [3] = '{1'b1, 1'b0, 1'b1};
   int          nrd [3] = '{2, 2, 4};
   int unsigned msk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
   int unsigned mm  [3][32];
   bit          in_init [3] = '{1'b1, 1'b1, 1'b1};
   int          icnt [3] = '{0, 0, 0};

   function automatic bit get_we(input int d);
      case (d)
         0:       return we0;
         1:       return we1;
         default: return we2;
      endcase
   endfunction

   function automatic int unsigned get_wa(input int d);
      case (d)
         0:       return int'(wa0);
         1:       return int'(wa1);
         default: return int'(wa2);
      endcase
   endfunction

   function automatic int unsigned get_wd(input int d);
      case (d)
         0:       return wd0;
         1:       return wd1;
         default: return {16'd0, wd2};
      endcase
   endfunction

   function automatic int unsigned get_ra(input int d, input int k);
      case (d)
         0:       return int'(ra0[k*5 +: 5]);
         1:       return int'(ra1[k*5 +: 5]);
         default: return int'(ra2[k*3 +: 3]);
      endcase
   endfunction

   function automatic logic [31:0] get_rd(input int d, input int k);
      case (d)
         0:       return rdd0[k*32 +: 32];
         1:       return rdd1[k*32 +: 32];
         default: return {16'd0, rdd2[k*16 +: 16]};
      endcase
   endfunction

   function automatic logic get_busy(input int d);
      case (d)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic bit write_lands(input int d);
      return get_we(d) && !in_init[d] && !rst && !(zr[d] && get_wa(d) == 0);
   endfunction

   function automatic int unsigned model_read(input int d, input int unsigned a);
      if (in_init[d]) return 0;
      if (zr[d] && a == 0) return 0;
      if (write_lands(d) && get_wa(d) == a) return get_wd(d) & msk[d];
      return mm[d][a];
   endfunction

   // Advance the model by one rising edge using the inputs held across it.
   function automatic void model_step();
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            in_init[d] = 1'b1;
            icnt[d]    = 0;
         end else if (in_init[d]) begin
            mm[d][icnt[d]] = im[d] ? (icnt[d] & msk[d]) : 0;
            icnt[d]++;
            if (icnt[d] == dep[d]) in_init[d] = 1'b0;
         end else if (write_lands(d)) begin
            mm[d][get_wa(d)] = get_wd(d) & msk[d];
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < nrd[d]; k++)
            check($sformatf("%s_d%0d_p%0d", tag, d, k), get_rd(d, k), model_read(d, get_ra(d, k)));
         check($sformatf("%s_busy_d%0d", tag, d), {31'd0, get_busy(d)}, {31'd0, in_init[d]});
      end
   endtask

   // Release reset and count edges until each instance leaves init.
   task automatic run_init(input string tag, output int f0, output int f1, output int f2);
      int n;
      n  = 0;
      f0 = -1; f1 = -1; f2 = -1;
      rst = 1'b0;
      while (f0 < 0 && n < 60) begin
         ra0 = 10'($urandom); ra1 = 10'($urandom); ra2 = 12'($urandom);
         #1;
         check_all(tag);
         tick();
         n++;
         if (!busy0 && f0 < 0) f0 = n;
         if (!busy1 && f1 < 0) f1 = n;
         if (!busy2 && f2 < 0) f2 = n;
      end
   endtask

   initial begin
      int f0, f1, f2;
      rst = 1'b1;
      we0 = 0; we1 = 0; we2 = 0;
      wa0 = 0; wa1 = 0; wa2 = 0;
      wd0 = 0; wd1 = 0; wd2 = 0;
      ra0 = 0; ra1 = 0; ra2 = 0;

      // Reset for two cycles; outputs held at init state.
      tick();
      tick();
      check("rst_busy0", {31'd0, busy0}, 32'd1);
      check("rst_rd0", rdd0[31:0], 32'd0);
      check_all("rst");

      // Init with a write attempt to entry 3 throughout (must be dropped).
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF_FFFF;
      run_init("init", f0, f1, f2);
      check("init_len_d0", f0, 32);
      check("init_len_d1", f1, 32);
      check("init_len_d2", f2, 8);
      we0 = 1'b0;

      ra0 = {5'd31, 5'd7}; ra1 = {5'd31, 5'd7}; ra2 = {3'd7, 3'd5, 3'd2, 3'd1};
      #1;
      check("init_d0_r7",  rdd0[31:0],  32'd7);
      check("init_d0_r31", rdd0[63:32], 32'd31);
      check("init_d1_r7",  rdd1[31:0],  32'd0);
      check("init_d1_r31", rdd1[63:32], 32'd0);
      check("init_d2_r5",  {16'd0, rdd2[47:32]}, 32'd5);
      check_all("init_rd");
      ra0 = {5'd0, 5'd3};
      #1;
      check("drop_during_init", rdd0[31:0], 32'd3);

      // Write with same-cycle bypass, then persistence.
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra0 = {5'd5, 5'd5};
      #1;
      check("byp_p0", rdd0[31:0],  32'hDEAD_BEEF);
      check("byp_p1", rdd0[63:32], 32'hDEAD_BEEF);
      tick();
      we0 = 1'b0;
      #1;
      check("wr_persist", rdd0[31:0], 32'hDEAD_BEEF);

      // Zero register vs ordinary entry 0.
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra0 = {5'd5, 5'd0};
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; ra1 = {5'd5, 5'd0};
      #1;
      check("zr_during", rdd0[31:0], 32'd0);
      check("nzr_byp",   rdd1[31:0], 32'h1234);
      check_all("zero_w");
      tick();
      we0 = 1'b0; we1 = 1'b0;
      #1;
      check("zr_after",  rdd0[31:0], 32'd0);
      check("nzr_after", rdd1[31:0], 32'h1234);

      // Four ports on one address during a write to it.
      we2 = 1'b1; wa2 = 3'd6; wd2 = 16'hAAAA; ra2 = {3'd6, 3'd6, 3'd6, 3'd6};
      #1;
      for (int k = 0; k < 4; k++)
         check($sformatf("mp_same_p%0d", k), {16'd0, rdd2[k*16 +: 16]}, 32'h0000_AAAA);
      ra2 = {3'd7, 3'd1, 3'd6, 3'd6};
      #1;
      check("mp_p0", {16'd0, rdd2[15:0]},  32'h0000_AAAA);
      check("mp_p1", {16'd0, rdd2[31:16]}, 32'h0000_AAAA);
      check("mp_p2", {16'd0, rdd2[47:32]}, 32'd1);
      check("mp_p3", {16'd0, rdd2[63:48]}, 32'd7);
      tick();
      we2 = 1'b0;
      ra2 = {3'd0, 3'd4, 3'd6, 3'd6};
      #1;
      check("mp_persist", {16'd0, rdd2[15:0]}, 32'h0000_AAAA);
      check("mp_zero",    {16'd0, rdd2[63:48]}, 32'd0);

      // Random traffic against the model, biased toward read/write address collisions.
      for (int c = 0; c < 300; c++) begin
         we0 = 1'($urandom); we1 = 1'($urandom); we2 = 1'($urandom);
         ra0 = 10'($urandom); ra1 = 10'($urandom); ra2 = 12'($urandom);
         wd0 = $urandom; wd1 = $urandom; wd2 = 16'($urandom);
         wa0 = ($urandom_range(0, 2) == 0) ? ra0[4:0] : 5'($urandom);
         wa1 = ($urandom_range(0, 2) == 0) ? ra1[9:5] : 5'($urandom);
         wa2 = ($urandom_range(0, 2) == 0) ? ra2[8:6] : 3'($urandom);
         #1;
         check_all("rand");
         tick();
      end
      we0 = 0; we1 = 0; we2 = 0;

      // Reset mid-init: restart after 10 init edges; full sequence must follow.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("mid_busy", {31'd0, busy0}, 32'd1);
      rst = 1'b1;
      tick();
      run_init("reinit", f0, f1, f2);
      check("reinit_len_d0", f0, 32);
      for (int i = 0; i < 32; i++) begin
         ra0 = {5'(31 - i), 5'(i)};
         #1;
         check($sformatf("reinit_e%0d", i), rdd0[31:0], (i == 0) ? 32'd0 : 32'(i));
         check_all("reinit_rd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Configurable data width, depth and number of combinational read ports.
- Adds three things the old file did not have:
  - write-to-read bypass, so a read in the same cycle as a write sees the new data;
  - an optional hardwired zero register;
  - a reset-driven initialisation sequencer that loads every entry, one per cycle, instead of using a simulation-only initial block.
- Sits in the decode stage of the MIPS datapath, feeding the ALU operand muxes.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent read ports, 1..4.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- INIT_MODE, 1: reset load value. 0 = all zeros; 1 = entry i loaded with i, zero-extended to DATA_W.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- rd_addr, in, NUM_RD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W: packed read data; port k uses bits [k*DATA_W +: DATA_W]. Combinational.
- wr_en, in, 1: write enable (RegWrite).
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- init_busy, out, 1: 1 while the init sequencer is running. Registered.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- State machine, states INIT and READY, with counter init_idx (ADDR_W bits).
  - rst=1 at an edge: next state is INIT, init_idx <= 0, init_busy <= 1. No array entry is written on that edge.
  - INIT with rst=0, at each edge:
    - mem[init_idx] <= init value: 0 when INIT_MODE=0, otherwise init_idx.
    - init_idx <= init_idx+1, wrapping.
    - If init_idx == DEPTH-1, go to READY and set init_busy <= 0.
  - Timing: init_busy is high for exactly DEPTH edges after the first edge with rst=0.
  - READY: stays in READY until rst is asserted. Asserting rst mid-INIT restarts the sequence from index 0.
- Reset value of outputs: init_busy = 1. rd_data = 0 on all ports while init_busy = 1.
- Writes:
  - Taken on a rising edge when wr_en=1, init_busy=0 and rst=0.
  - When ZERO_REG=1 and wr_addr=0, the write is dropped.
  - wr_en while init_busy=1 is dropped silently; no queueing.
- Reads: combinational, per port k:
  - if init_busy: 0;
  - else if ZERO_REG and rd_addr[k]==0: 0;
  - else if wr_en and wr_addr==rd_addr[k]: wr_data (bypass, same cycle);
  - else: mem[rd_addr[k]].
- Bypass rules:
  - Bypass applies only to writes that will actually commit; the zero-register and init_busy cases do not bypass.
  - All ports reading the same address return identical data.
- Latency:
  - Read: 0 cycles.
  - Write: visible to a non-bypassed read from the cycle after the edge.
- Array storage: not reset directly; its contents are defined only after INIT completes.
- Widths:
  - The init value is zero-extended or truncated to DATA_W.
  - Address decode uses full ADDR_W; there are no out-of-range entries.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum INIT/READY;
  - localparam DEPTH derivation;
  - helper function init_value(idx, mode).
- One sub-module, regfile_rd_port: combinational mux covering zero, bypass and array read. Instantiated NUM_RD times in a generate loop.
- The init FSM and the array stay in the top module.

Test Plan:
1. Reset and init, defaults: rst=1 for 2 cycles, then 0.
   - init_busy=1 for exactly 32 edges, then 0.
   - rd_addr port0=7, port1=31 read 7 and 31.
   - With INIT_MODE=0, both read 0.
2. Write, then read:
   - wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
   - In the same cycle, port0 reading 5 returns 0xDEADBEEF (bypass).
   - After the edge, with wr_en=0, it still returns 0xDEADBEEF.
3. Zero register:
   - Write 0x1234 to address 0: port0 at address 0 reads 0 during and after the write.
   - With ZERO_REG=0, the same write reads back 0x1234.
4. Write during init:
   - wr_en=1, wr_addr=3, wr_data=0xFFFF_FFFF while init_busy=1.
   - rd_data stays 0 throughout.
   - After init completes, address 3 reads 3 (write dropped).
5. Reset mid-init:
   - Assert rst at init_idx=10, release.
   - init_busy stays high for a full 32 edges from release.
   - All entries hold i afterwards.
6. Multi-port, NUM_RD=4, DATA_W=16, ADDR_W=3:
   - All four ports read address 6 while writing 0xAAAA to address 6.
   - All four return 0xAAAA in that cycle.
   - Ports reading other addresses return their own unchanged values.
